// File: rtl/phase_duration_counter.sv
// Per-phase countdown for the washer controller: loads the duration of each new
// phase on a state change, counts down while not paused, and pulses timeout on expiry.
module phase_duration_counter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             state_dc,
  input  logic [COUNT_WIDTH-1:0] filling_count_dc,
  input  logic [COUNT_WIDTH-1:0] washing_count_dc,
  input  logic [COUNT_WIDTH-1:0] rinsing_count_dc,
  input  logic [COUNT_WIDTH-1:0] spinning_count_dc,
  input  logic                   pause_dc,
  output logic                   timeout_dc,
  output logic                   running_dc,
  output logic [COUNT_WIDTH-1:0] remaining_dc
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} fsm_t;

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  fsm_t                   fsm_q, fsm_d;
  logic [2:0]             state_prev;
  logic [COUNT_WIDTH-1:0] rem_d, load_val;
  logic                   load_active, tmo_d, change;

  assign change = (state_dc != state_prev);

  // Duration lookup for the incoming phase; idle and invalid codes load zero.
  always_comb begin
    load_active = 1'b1;
    load_val    = '0;
    case (state_dc)
      3'b001:  load_val = filling_count_dc;
      3'b010:  load_val = washing_count_dc;
      3'b011:  load_val = rinsing_count_dc;
      3'b100:  load_val = spinning_count_dc;
      default: load_active = 1'b0;
    endcase
  end

  // A change always wins over pause/decrement, so a reload in the cycle the old
  // phase would hit zero suppresses that phase's timeout.
  always_comb begin
    fsm_d = fsm_q;
    rem_d = remaining_dc;
    tmo_d = 1'b0;
    if (change) begin
      rem_d = load_val;
      if (!load_active) begin
        fsm_d = IDLE;
      end else if (load_val == '0) begin
        fsm_d = EXPIRED;
        tmo_d = 1'b1;
      end else begin
        fsm_d = RUN;
      end
    end else begin
      case (fsm_q)
        RUN, PAUSED: begin
          if (pause_dc) begin
            fsm_d = PAUSED;
          end else begin
            rem_d = remaining_dc - ONE;
            if (remaining_dc == ONE) begin
              fsm_d = EXPIRED;
              tmo_d = 1'b1;
            end else begin
              fsm_d = RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_prev   <= 3'b000;
      fsm_q        <= IDLE;
      remaining_dc <= '0;
      running_dc   <= 1'b0;
      timeout_dc   <= 1'b0;
    end else begin
      state_prev   <= state_dc;
      fsm_q        <= fsm_d;
      remaining_dc <= rem_d;
      running_dc   <= (fsm_d == RUN);
      timeout_dc   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_phase_duration_counter.sv
// Scoreboard bench for phase_duration_counter: expected outputs for cycle k+1 are
// queued while cycle k inputs are driven, then popped and compared mid-cycle.
module tb_phase_duration_counter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   state_dc;
  logic [W-1:0] filling_count_dc, washing_count_dc, rinsing_count_dc, spinning_count_dc;
  logic         pause_dc;
  logic         timeout_dc, running_dc;
  logic [W-1:0] remaining_dc;

  typedef struct packed {
    logic [W-1:0] rem;
    logic         run;
    logic         tmo;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  phase_duration_counter #(.COUNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .state_dc(state_dc),
    .filling_count_dc(filling_count_dc), .washing_count_dc(washing_count_dc),
    .rinsing_count_dc(rinsing_count_dc), .spinning_count_dc(spinning_count_dc),
    .pause_dc(pause_dc), .timeout_dc(timeout_dc), .running_dc(running_dc),
    .remaining_dc(remaining_dc)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int r, bit ru, bit t);
    exp_t e;
    e.rem = 32'(r);
    e.run = ru;
    e.tmo = t;
    return e;
  endfunction

  task automatic go_idle();
    @(negedge clk);
    rst = 1'b0; state_dc = 3'b000; pause_dc = 1'b0;
    @(posedge clk);
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; state_dc = 3'b010; pause_dc = 1'b0;
    filling_count_dc = 32'd7; washing_count_dc = 32'd7;
    rinsing_count_dc = 32'd7; spinning_count_dc = 32'd7;
    sb.push_back(mk(0, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
      n_fail++;
      $display("FAIL reset: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
               remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
    end
    state_dc = 3'b000;
    sb.push_back(mk(0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    e = sb.pop_front(); n_tests++;
    if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
      n_fail++;
      $display("FAIL reset_release: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
               remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
    end
    sb.delete();
  endtask

  task automatic test_filling();
    exp_t e;
    int   k;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = sb.pop_front(); n_tests++;
        if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
          n_fail++;
          $display("FAIL filling cyc%0d: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
                   c, remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
        end
      end
      state_dc = 3'b001; filling_count_dc = 32'd5;
      k = c + 1;
      sb.push_back(mk((k <= 5) ? 6 - k : 0, k <= 5, k == 6));
    end
    sb.delete();
  endtask

  task automatic test_pause();
    exp_t e;
    int   rem_t[10] = '{4, 3, 3, 3, 3, 2, 1, 0, 0, 0};
    bit   run_t[10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = sb.pop_front(); n_tests++;
        if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
          n_fail++;
          $display("FAIL pause cyc%0d: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
                   c, remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
        end
      end
      state_dc = 3'b010; washing_count_dc = 32'd4;
      pause_dc = (c >= 2 && c <= 4);
      if (c < 10) sb.push_back(mk(rem_t[c], run_t[c], c + 1 == 8));
    end
    sb.delete();
  endtask

  task automatic test_pause_edges();
    exp_t e;
    bit   pz_t[8]  = '{1, 1, 0, 1, 1, 0, 0, 0};
    int   rem_t[8] = '{2, 2, 1, 1, 1, 0, 0, 0};
    bit   run_t[8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = sb.pop_front(); n_tests++;
        if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
          n_fail++;
          $display("FAIL pause_edges cyc%0d: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
                   c, remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
        end
      end
      if (c < 8) begin
        state_dc = 3'b001; filling_count_dc = 32'd2; pause_dc = pz_t[c];
        sb.push_back(mk(rem_t[c], run_t[c], c + 1 == 6));
      end
    end
    sb.delete();
  endtask

  task automatic test_zero();
    exp_t e;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = sb.pop_front(); n_tests++;
        if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
          n_fail++;
          $display("FAIL zero cyc%0d: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
                   c, remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
        end
      end
      state_dc = 3'b011; rinsing_count_dc = 32'd0;
      sb.push_back(mk(0, 1'b0, c == 0));
    end
    sb.delete();
  endtask

  task automatic test_switch();
    exp_t e;
    int   rem_t[6] = '{10, 9, 8, 2, 1, 0};
    int   k;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = sb.pop_front(); n_tests++;
        if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
          n_fail++;
          $display("FAIL switch cyc%0d: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
                   c, remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
        end
      end
      state_dc = (c < 3) ? 3'b001 : 3'b010;
      filling_count_dc = 32'd10; washing_count_dc = 32'd2;
      k = c + 1;
      sb.push_back(mk((k <= 6) ? rem_t[k-1] : 0, k <= 5, k == 6));
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   rem_t[6] = '{3, 2, 1, 2, 1, 0};
    int   k;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = sb.pop_front(); n_tests++;
        if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
          n_fail++;
          $display("FAIL back_to_back cyc%0d: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
                   c, remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
        end
      end
      state_dc = (c < 3) ? 3'b001 : 3'b010;
      filling_count_dc = 32'd3; washing_count_dc = 32'd2;
      k = c + 1;
      sb.push_back(mk((k <= 6) ? rem_t[k-1] : 0, k <= 5, k == 6));
    end
    sb.delete();
  endtask

  task automatic test_idle_invalid();
    exp_t e;
    int   k;
    for (int c = 0; c <= 43; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = sb.pop_front(); n_tests++;
        if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
          n_fail++;
          $display("FAIL idle_invalid cyc%0d: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
                   c, remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
        end
      end
      state_dc = (c < 3) ? 3'b001 : (c < 23) ? 3'b110 : 3'b000;
      filling_count_dc = 32'd9;
      k = c + 1;
      sb.push_back(mk((k <= 3) ? 10 - k : 0, k <= 3, 1'b0));
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   rem_t[6] = '{9, 8, 7, 0, 9, 8};
    bit   run_t[6] = '{1, 1, 1, 0, 1, 1};
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = sb.pop_front(); n_tests++;
        if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
          n_fail++;
          $display("FAIL reset_mid_run cyc%0d: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
                   c, remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
        end
      end
      if (c < 6) begin
        state_dc = 3'b001; filling_count_dc = 32'd9; rst = (c == 3);
        sb.push_back(mk(rem_t[c], run_t[c], 1'b0));
      end
    end
    sb.delete();
  endtask

  task automatic test_spinning_hold();
    exp_t e;
    int   k;
    for (int c = 0; c <= 54; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = sb.pop_front(); n_tests++;
        if ({remaining_dc, running_dc, timeout_dc} !== {e.rem, e.run, e.tmo}) begin
          n_fail++;
          $display("FAIL spinning cyc%0d: got rem=%0d run=%b tmo=%b, want rem=%0d run=%b tmo=%b",
                   c, remaining_dc, running_dc, timeout_dc, e.rem, e.run, e.tmo);
        end
      end
      state_dc = 3'b100;
      spinning_count_dc = (c < 2) ? 32'd3 : 32'd100;
      k = c + 1;
      sb.push_back(mk((k <= 3) ? 4 - k : 0, k <= 3, k == 4));
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    go_idle(); test_filling();
    go_idle(); test_pause();
    go_idle(); test_pause_edges();
    go_idle(); test_zero();
    go_idle(); test_switch();
    go_idle(); test_back_to_back();
    go_idle(); test_idle_invalid();
    go_idle(); test_reset_mid_run();
    go_idle(); test_spinning_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
